// File: rtl/slow_receiver2.sv
// ============================================================================
// Module   : slow_receiver2
// Brief    : Serial-to-parallel receiver for 128-bit slow-link frames.
//            Optional even parity is enabled by defining SLOWLINK_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slow_receiver2 #(
    parameter int bit_clk_divider = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         serial_i,
    output logic [127:0] payload_o,
    output logic         valid_o,
    output logic         frame_error_o,
    output logic         busy_o
);

    localparam int CNT_W = $clog2(bit_clk_divider);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(bit_clk_divider / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(bit_clk_divider - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef SLOWLINK_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic             sync1_q, sync2_q, prev_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       idx_q, idx_d;
    logic [127:0]     shift_q, shift_d;
    logic [127:0]     payload_q, payload_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             parity_ok;

`ifdef SLOWLINK_PARITY_EN
    logic             parity_ok_q, parity_ok_d;
    assign parity_ok = parity_ok_q;
`else
    assign parity_ok = 1'b1;
`endif

    // State register; the synchronizer idles high so reset never looks like a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            payload_q   <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
`ifdef SLOWLINK_PARITY_EN
            parity_ok_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= serial_i;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            payload_q   <= payload_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
`ifdef SLOWLINK_PARITY_EN
            parity_ok_q <= parity_ok_d;
`endif
        end
    end

    // Next-state logic; every sample is taken in the cycle where cnt_q reaches zero
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        payload_d   = payload_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
`ifdef SLOWLINK_PARITY_EN
        parity_ok_d = parity_ok_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (prev_q && !sync2_q) begin
                    cnt_d   = CNT_HALF;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (!sync2_q) begin
                        cnt_d   = CNT_FULL;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[127:1]};
                    cnt_d   = CNT_FULL;
                    idx_d   = idx_q + 7'd1;
                    if (idx_q == 7'd127) begin
`ifdef SLOWLINK_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef SLOWLINK_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    parity_ok_d = (sync2_q == ^shift_q);
                    cnt_d       = CNT_FULL;
                    state_d     = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (sync2_q && parity_ok) begin
                        payload_d = shift_q;
                        valid_d   = 1'b1;
                    end else begin
                        ferr_d    = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        payload_o     = payload_q;
        valid_o       = valid_q;
        frame_error_o = ferr_q;
        busy_o        = (state_q != ST_IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_slow_receiver2.sv
// ============================================================================
// Module   : tb_slow_receiver2
// Brief    : Directed self-checking bench for slow_receiver2 (D = 5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slow_receiver2;

    localparam int D = 5;
    localparam int H = D / 2;
`ifdef SLOWLINK_PARITY_EN
    localparam int NB = 130;
`else
    localparam int NB = 129;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         serial_i = 1'b1;
    logic [127:0] payload_o;
    logic         valid_o;
    logic         frame_error_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int start_edge = 0;

    int           vcount = 0;
    int           fcount = 0;
    int           busy_total = 0;
    int           last_vcyc = 0;
    int           prev_vcyc = 0;
    logic [127:0] last_vpay = '0;
    logic [127:0] prev_vpay = '0;
    logic         both_seen = 1'b0;

    slow_receiver2 #(.bit_clk_divider(D)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .serial_i      (serial_i),
        .payload_o     (payload_o),
        .valid_o       (valid_o),
        .frame_error_o (frame_error_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Pulse recorder sampled on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        if (valid_o) begin
            vcount    <= vcount + 1;
            prev_vcyc <= last_vcyc;
            last_vcyc <= cycle;
            prev_vpay <= last_vpay;
            last_vpay <= payload_o;
        end
        if (frame_error_o) fcount <= fcount + 1;
        if (valid_o && frame_error_o) both_seen <= 1'b1;
        if (busy_o) busy_total <= busy_total + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; leaves the line idle-high on return
    task automatic send_frame(input logic [127:0] data, input logic corrupt);
        serial_i   = 1'b0;
        start_edge = cycle + 1;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            serial_i = data[i];
            repeat (D) @(negedge clk);
        end
`ifdef SLOWLINK_PARITY_EN
        serial_i = (^data) ^ corrupt;
        repeat (D) @(negedge clk);
`endif
        serial_i = ~corrupt;
        repeat (D) @(negedge clk);
        serial_i = 1'b1;
    endtask

    initial begin
        int v0, f0, b0;
        logic [127:0] abort_data;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_payload", payload_o, 128'd0);
        chk("rst_valid", {127'd0, valid_o}, 128'd0);
        chk("rst_ferr", {127'd0, frame_error_o}, 128'd0);
        chk("rst_busy", {127'd0, busy_o}, 128'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame with latency
        send_frame({4{32'hDEADBEEF}}, 1'b0);
        repeat (3 * D) @(negedge clk);
        chk("f1_vcount", 128'(vcount), 128'd1);
        chk("f1_payload", payload_o, {4{32'hDEADBEEF}});
        chk("f1_latency", 128'(last_vcyc - start_edge), 128'(3 + H + NB * D));
        chk("f1_ferr", 128'(fcount), 128'd0);

        // Back-to-back frames
        send_frame(128'h1, 1'b0);
        send_frame({128{1'b1}}, 1'b0);
        repeat (3 * D) @(negedge clk);
        chk("b2b_vcount", 128'(vcount), 128'd3);
        chk("b2b_pay0", prev_vpay, 128'h1);
        chk("b2b_pay1", last_vpay, {128{1'b1}});
        chk("b2b_spacing", 128'(last_vcyc - prev_vcyc), 128'((NB + 1) * D));
        chk("b2b_ferr", 128'(fcount), 128'd0);

        // One-cycle glitch on idle line
        b0 = busy_total;
        serial_i = 1'b0;
        @(negedge clk);
        serial_i = 1'b1;
        repeat (4 * D) @(negedge clk);
        chk("gl_busy_bound", {127'd0, ((busy_total - b0) <= H + 3)}, 128'd1);
        chk("gl_busy_seen", {127'd0, ((busy_total - b0) > 0)}, 128'd1);
        chk("gl_vcount", 128'(vcount), 128'd3);
        chk("gl_ferr", 128'(fcount), 128'd0);
        chk("gl_idle", {127'd0, busy_o}, 128'd0);

        // Corrupted stop (and parity) bit
        send_frame({4{32'hCAFEF00D}}, 1'b1);
        repeat (3 * D) @(negedge clk);
        chk("se_ferr", 128'(fcount), 128'd1);
        chk("se_payload", payload_o, {128{1'b1}});
        chk("se_vcount", 128'(vcount), 128'd3);

        // Reset during data bit 60
        v0 = vcount;
        f0 = fcount;
        abort_data = {4{32'h0F1E2D3C}};
        serial_i = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            serial_i = abort_data[i];
            repeat (D) @(negedge clk);
        end
        repeat (H) @(negedge clk);
        rst_n    = 1'b0;
        serial_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("ab_payload", payload_o, 128'd0);
        chk("ab_busy", {127'd0, busy_o}, 128'd0);
        rst_n = 1'b1;
        repeat (4 * D) @(negedge clk);
        chk("ab_no_pulse", 128'((vcount - v0) + (fcount - f0)), 128'd0);
        send_frame({4{32'h12345678}}, 1'b0);
        repeat (3 * D) @(negedge clk);
        chk("ab_next_payload", payload_o, {4{32'h12345678}});
        chk("ab_next_vcount", 128'(vcount - v0), 128'd1);

        // Break: line held low
        v0 = vcount;
        f0 = fcount;
        serial_i = 1'b0;
        repeat (300 * D) @(negedge clk);
        chk("brk_ferr", 128'(fcount - f0), 128'd1);
        chk("brk_idle", {127'd0, busy_o}, 128'd0);
        serial_i = 1'b1;
        repeat (4 * D) @(negedge clk);
        chk("brk_ferr_after", 128'(fcount - f0), 128'd1);
        send_frame({4{32'hA5A5A5A5}}, 1'b0);
        repeat (3 * D) @(negedge clk);
        chk("brk_payload", payload_o, {4{32'hA5A5A5A5}});
        chk("brk_vcount", 128'(vcount - v0), 128'd1);

        chk("no_overlap", {127'd0, both_seen}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slow_receiver2.md
# slow_receiver2

Serial-to-parallel receiver for the slow link: recovers 128-bit frames from the single-wire output of `SlowTransmitter2` and presents each frame as one parallel payload with a one-cycle valid strobe. It sits directly downstream of the transmitter, on the far end of the link, clocked at the same nominal frequency and configured with the same bit divider.

## Interface
Parameters:
- `bit_clk_divider`, default 5: clock cycles per serial bit; must equal the transmitter setting; minimum 3.

Ports:
- `clk`  input  1  system clock
- `reset`  input  1  asynchronous, active-low reset (0 = reset)
- `serial_i`  input  1  serial line; asynchronous to `clk`; idle level 1
- `payload_o`  output  128  last correctly received frame (`payload_t`)
- `valid_o`  output  1  one-cycle pulse: `payload_o` updated this cycle
- `frame_error_o`  output  1  one-cycle pulse: frame rejected
- `busy_o`  output  1  1 while a frame is being received (state ≠ IDLE)

## Operation
- Wire format: start bit (0), 128 data bits LSB first (`payload[0]` first), optional parity bit (see Configuration), stop bit (1). Line idles at 1.
- `serial_i` passes through a 2-FF synchronizer. Both FFs reset to 1. A third register holds the previous synchronized value for edge detection.
- Down-counter `cnt` paces sampling. Bit index `idx` runs 0..127.
- States:
  - IDLE: on a synchronized falling edge (prev=1, cur=0), load `cnt = floor(D/2)` and go to START.
  - START: decrement `cnt`; at `cnt==0`, sample. If 0: load `cnt = D-1`, set `idx = 0`, go to DATA. If 1: treat as a glitch, return to IDLE with no error pulse.
  - DATA: at `cnt==0`, shift the sample into the MSB of a 128-bit shift register (right shift), reload `cnt = D-1`, increment `idx`. After the sample with `idx==127`, go to PARITY (macro on) or STOP (macro off).
  - PARITY: at `cnt==0`, sample and latch `parity_ok = (sample == ^shift)`, reload `cnt`, go to STOP.
  - STOP: at `cnt==0`, sample. If the sample is 1 and `parity_ok` (forced 1 when the macro is off): copy the shift register to `payload_o` and pulse `valid_o`. Otherwise pulse `frame_error_o` and leave `payload_o` unchanged. Go to IDLE.
- The next frame is accepted only after the line is seen high and then low again. Back-to-back frames (start bit immediately after stop bit) are received.
- A line held low (break) produces exactly one `frame_error_o`, then the block waits in IDLE until the line has returned to 1.
- `valid_o` and `frame_error_o` are never asserted in the same cycle.

## Timing
- Reset values: `payload_o = 0`, `valid_o = 0`, `frame_error_o = 0`, `busy_o = 0`, state IDLE, synchronizer = 1.
- Reset asserted mid-frame: immediate return to IDLE, all outputs cleared, partial frame discarded, no pulse.
- Samples fall at the middle of each bit: floor(D/2) cycles after the detected edge, then every D cycles.
- Latency: `valid_o` is high in the cycle after the stop sample, which is 3 + floor(D/2) + N·D cycles after the first `clk` edge that captures `serial_i` low. N = 129 without parity, 130 with parity.
- Output pulses are exactly one cycle wide. `payload_o` is stable between `valid_o` pulses.
- Tolerated clock mismatch: sampling must stay within ±floor(D/2) cycles of the bit centre over a whole frame.

## Configuration
- `SLOWLINK_PARITY_EN` must be defined identically for transmitter and receiver.
  - Defined: the frame carries an even-parity bit after data bit 127, and a parity mismatch raises `frame_error_o`.
  - Undefined: no parity bit is expected, the PARITY state is omitted, and only the stop bit is checked.

## Test plan
- Frame of data 0xDEADBEEF replicated ×4 from `SlowTransmitter2` (D=5) → one `valid_o` pulse; `payload_o = {4{32'hDEADBEEF}}`; latency matches the Timing formula exactly.
- Two back-to-back frames, 0x00000001 then 0xFFFFFFFF → two `valid_o` pulses spaced N·D+D cycles apart; correct payloads; no `frame_error_o`.
- 1-cycle low glitch on an idle line → no pulses; `busy_o` high for at most floor(D/2)+3 cycles, then IDLE.
- Stop bit forced to 0 (and, with the macro on, parity inverted) → one `frame_error_o` pulse; `payload_o` keeps the previous value.
- Reset pulsed at data bit 60, then a clean frame 0x12345678 → no pulse from the aborted frame; `payload_o` reads 0 after reset; the next frame is received correctly.
- Line held low for 300·D cycles → exactly one `frame_error_o`; after the line returns high, a frame 0xA5A5A5A5 is received.
